// File: rtl/fft_stream_pkg.sv
// Purpose: shared state type and sizing constants for the FFT result streamer.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package fft_stream_pkg;

   localparam int BFP_EXP_W  = 8;
   localparam int SKID_DEPTH = 2;
   localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_FIN,
      ST_WAIT_CLR
   } streamer_state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Purpose: 2-entry buffer that absorbs the one-cycle DMA read latency.
// Latency: a push is visible at head_dat on the cycle after the push edge.
// Backpressure: none internally; the caller never pushes into a full buffer unless it pops in that cycle.
//
// Ports: clk/rst; push + push_dat write an entry; pop retires the head;
//        flush empties the buffer and wins over push/pop; head_dat is the
//        oldest entry; count is the current occupancy.
module stream_skid_fifo
   import fft_stream_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [W-1:0]          push_dat,
   input  logic                  pop,
   input  logic                  flush,
   output logic [W-1:0]          head_dat,
   output logic [SKID_CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(SKID_DEPTH);

   logic [W-1:0]     mem [SKID_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
      end
   end

   assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fft_result_streamer.sv
// Purpose: drains a finished FFT frame over the DMA read bus as a valid/ready stream in bin order.
// Latency: first beat valid 2 cycles after READ entry; 1 beat/cycle sustained with m_ready high.
// Backpressure: m_ready low stalls the head beat; reads are throttled so at most 2 beats are stored or in flight.
//
// Ports: done/bfpexp/half_spectrum from the core; fin back to the core;
//        dmaact/dmaa/dmadr_* DMA read bus (data one cycle after dmaact);
//        m_* output stream with bin index, last flag and frame exponent;
//        busy while a frame is owned; abort pulses when done drops mid-frame.
module fft_result_streamer
   import fft_stream_pkg::*;
#(
   parameter  int FFT_LENGTH = 1024,
   parameter  int FFT_DW     = 16,
   localparam int FFT_N      = $clog2(FFT_LENGTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        done,
   input  logic signed [BFP_EXP_W-1:0] bfpexp,
   input  logic                        half_spectrum,
   output logic                        fin,
   output logic                        dmaact,
   output logic [FFT_N-1:0]            dmaa,
   input  logic signed [FFT_DW-1:0]    dmadr_real,
   input  logic signed [FFT_DW-1:0]    dmadr_imag,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic signed [FFT_DW-1:0]    m_real,
   output logic signed [FFT_DW-1:0]    m_imag,
   output logic [FFT_N-1:0]            m_index,
   output logic                        m_last,
   output logic signed [BFP_EXP_W-1:0] m_bfpexp,
   output logic                        busy,
   output logic                        abort
);

   localparam int COMMIT_W = SKID_CNT_W + 1;

   typedef struct packed {
      logic                     last;
      logic [FFT_N-1:0]         index;
      logic signed [FFT_DW-1:0] im;
      logic signed [FFT_DW-1:0] re;
   } beat_t;

   streamer_state_t             state;
   streamer_state_t             nxt_state;
   logic [FFT_N-1:0]            rd_addr;
   logic [FFT_N-1:0]            dmaa_hold;
   logic [FFT_N-1:0]            pend_idx;
   logic [FFT_N-1:0]            last_addr;
   logic                        rd_pending;
   logic                        half_q;
   logic signed [BFP_EXP_W-1:0] bfp_q;
   logic [SKID_CNT_W-1:0]       fifo_cnt;
   logic [COMMIT_W-1:0]         committed;
   logic                        frame_start;
   logic                        abort_now;
   logic                        pop;
   logic                        issue;
   logic                        flush;
   beat_t                       push_beat;
   beat_t                       head_beat;

   assign last_addr   = half_q ? FFT_N'(FFT_LENGTH / 2 - 1) : FFT_N'(FFT_LENGTH - 1);
   assign frame_start = (state == ST_IDLE) && done;
   assign abort_now   = ((state == ST_READ) || (state == ST_DRAIN)) && !done;

   assign m_valid = (fifo_cnt != '0);
   assign pop     = m_valid && m_ready;

   // Slots already spoken for once this cycle settles: stored beats plus the
   // read returning now, less the beat leaving now. A new read may only be
   // issued if it still fits, which keeps the 2-entry buffer from overflowing.
   assign committed = COMMIT_W'(fifo_cnt) + COMMIT_W'(rd_pending) - COMMIT_W'(pop);
   assign issue     = (state == ST_READ) && done && (committed < COMMIT_W'(SKID_DEPTH));

   // Starting a frame discards anything left over; aborting drops stored
   // beats and the read returning this cycle (flush wins over push).
   assign flush = abort_now || frame_start;

   always_comb begin
      push_beat       = '0;
      push_beat.last  = (pend_idx == last_addr);
      push_beat.index = pend_idx;
      push_beat.im    = dmadr_imag;
      push_beat.re    = dmadr_real;
   end

   stream_skid_fifo #(
      .W($bits(beat_t))
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .push     (rd_pending),
      .push_dat (push_beat),
      .pop      (pop),
      .flush    (flush),
      .head_dat (head_beat),
      .count    (fifo_cnt)
   );

   assign m_real   = head_beat.re;
   assign m_imag   = head_beat.im;
   assign m_index  = head_beat.index;
   assign m_last   = head_beat.last;
   assign m_bfpexp = bfp_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt_state;
      end
   end

   // Next-state logic.
   always_comb begin
      nxt_state = state;
      unique case (state)
         ST_IDLE: begin
            if (done) nxt_state = ST_READ;
         end
         ST_READ: begin
            if (!done)                               nxt_state = ST_IDLE;
            else if (issue && rd_addr == last_addr)  nxt_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!done)                     nxt_state = ST_IDLE;
            else if (pop && head_beat.last) nxt_state = ST_FIN;
         end
         ST_FIN: begin
            nxt_state = ST_WAIT_CLR;
         end
         ST_WAIT_CLR: begin
            // done must fall before another frame is accepted.
            if (!done) nxt_state = ST_IDLE;
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      fin    = (state == ST_FIN);
      busy   = (state != ST_IDLE);
      abort  = abort_now;
      dmaact = issue;
      dmaa   = issue ? rd_addr : dmaa_hold;
   end

   // Address, in-flight tag and frame-constant captures.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr    <= '0;
         dmaa_hold  <= '0;
         pend_idx   <= '0;
         rd_pending <= 1'b0;
         half_q     <= 1'b0;
         bfp_q      <= '0;
      end else begin
         if (frame_start) begin
            rd_addr <= '0;
            half_q  <= half_spectrum;
            bfp_q   <= bfpexp;
         end
         if (issue) begin
            dmaa_hold <= rd_addr;
            pend_idx  <= rd_addr;
            // Stop at the last address so the counter never wraps in a frame.
            if (rd_addr != last_addr) begin
               rd_addr <= rd_addr + FFT_N'(1);
            end
         end
         rd_pending <= issue;
      end
   end

endmodule

// File: tb/tb_fft_result_streamer.sv
module tb_fft_result_streamer;

   localparam int N  = 16;
   localparam int DW = 16;
   localparam int AW = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 done;
   logic signed [7:0]    bfpexp;
   logic                 half_spectrum;
   logic                 fin;
   logic                 dmaact;
   logic [AW-1:0]        dmaa;
   logic signed [DW-1:0] dmadr_real;
   logic signed [DW-1:0] dmadr_imag;
   logic                 m_valid;
   logic                 m_ready;
   logic signed [DW-1:0] m_real;
   logic signed [DW-1:0] m_imag;
   logic [AW-1:0]        m_index;
   logic                 m_last;
   logic signed [7:0]    m_bfpexp;
   logic                 busy;
   logic                 abort;

   int checks = 0;
   int errors = 0;

   // Reference frame contents and expectations.
   logic signed [DW-1:0] mem_re [N];
   logic signed [DW-1:0] mem_im [N];
   int                   exp_n;
   logic signed [7:0]    exp_bfp;

   // Monitor records.
   int                   cyc = 0;
   logic [AW-1:0]        acc_idx[$];
   logic signed [DW-1:0] acc_re[$];
   logic signed [DW-1:0] acc_im[$];
   logic                 acc_last[$];
   int                   acc_cyc[$];
   logic [AW-1:0]        addr_q[$];
   int                   addr_cyc[$];
   int                   issued, accepted, fin_cnt, abort_cnt, bfp_bad, stab_bad, max_out;
   logic                 hold_prev = 1'b0;
   logic [AW-1:0]        p_idx;
   logic signed [DW-1:0] p_re, p_im;
   logic                 p_last;

   // Ready driver control.
   int                   ready_mode = 0;
   logic [AW-1:0]        stall_idx = 4'd4;
   int                   stall_left = 0;
   logic                 stall_done = 1'b0;

   fft_result_streamer #(
      .FFT_LENGTH(N),
      .FFT_DW    (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .done         (done),
      .bfpexp       (bfpexp),
      .half_spectrum(half_spectrum),
      .fin          (fin),
      .dmaact       (dmaact),
      .dmaa         (dmaa),
      .dmadr_real   (dmadr_real),
      .dmadr_imag   (dmadr_imag),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_real       (m_real),
      .m_imag       (m_imag),
      .m_index      (m_index),
      .m_last       (m_last),
      .m_bfpexp     (m_bfpexp),
      .busy         (busy),
      .abort        (abort)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   // DMA memory: data valid the cycle after dmaact, garbage otherwise.
   always @(posedge clk) begin
      if (dmaact) begin
         dmadr_real <= mem_re[dmaa];
         dmadr_imag <= mem_im[dmaa];
      end else begin
         dmadr_real <= DW'($urandom);
         dmadr_imag <= DW'($urandom);
      end
   end

   // Consumer ready pattern: 0 = always ready, 1 = toggle with a 5-cycle
   // stall when bin stall_idx reaches the head, 2 = random.
   always @(negedge clk) begin
      if (ready_mode == 1) begin
         if (stall_left > 0) begin
            m_ready    = 1'b0;
            stall_left = stall_left - 1;
         end else if (!stall_done && m_valid && m_index == stall_idx) begin
            stall_done = 1'b1;
            stall_left = 4;
            m_ready    = 1'b0;
         end else begin
            m_ready = ~m_ready;
         end
      end else if (ready_mode == 2) begin
         m_ready = ($urandom_range(3) != 0);
      end else begin
         m_ready = 1'b1;
      end
   end

   // Observe one time unit before each rising edge.
   always @(negedge clk) begin
      #4;
      cyc = cyc + 1;
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev && !abort) begin
            if (!m_valid || m_index !== p_idx || m_real !== p_re || m_imag !== p_im || m_last !== p_last)
               stab_bad = stab_bad + 1;
         end
         hold_prev = m_valid && !m_ready && !abort;
         p_idx = m_index; p_re = m_real; p_im = m_imag; p_last = m_last;
         if (m_valid && m_ready) begin
            acc_idx.push_back(m_index);
            acc_re.push_back(m_real);
            acc_im.push_back(m_imag);
            acc_last.push_back(m_last);
            acc_cyc.push_back(cyc);
            accepted = accepted + 1;
            if (m_bfpexp !== exp_bfp) bfp_bad = bfp_bad + 1;
         end
         if (dmaact) begin
            addr_q.push_back(dmaa);
            addr_cyc.push_back(cyc);
            issued = issued + 1;
         end
         if (issued - accepted > max_out) max_out = issued - accepted;
         if (fin)   fin_cnt   = fin_cnt + 1;
         if (abort) abort_cnt = abort_cnt + 1;
      end
   end

   task automatic clear_records();
      acc_idx.delete(); acc_re.delete(); acc_im.delete(); acc_last.delete(); acc_cyc.delete();
      addr_q.delete(); addr_cyc.delete();
      issued = 0; accepted = 0; fin_cnt = 0; abort_cnt = 0;
      bfp_bad = 0; stab_bad = 0; max_out = 0;
   endtask

   // Loads a random frame, builds the expectation and raises done.
   task automatic start_frame(input logic hf, input logic signed [7:0] e, input int mode);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         mem_re[i] = DW'($urandom);
         mem_im[i] = DW'($urandom);
      end
      exp_n   = hf ? N / 2 : N;
      exp_bfp = e;
      clear_records();
      ready_mode    = mode;
      stall_done    = 1'b0;
      stall_left    = 0;
      half_spectrum = hf;
      bfpexp        = e;
      done          = 1'b1;
      // Frame parameters must be captured at start, so disturb them afterwards.
      @(negedge clk);
      half_spectrum = ~hf;
      bfpexp        = 8'($urandom);
   endtask

   task automatic wait_fin(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (fin_cnt > 0) ok = 1'b1;
      end
   endtask

   task automatic end_frame();
      @(negedge clk);
      done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; done = 1'b0; half_spectrum = 1'b0; bfpexp = '0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      #4;
      checks++;
      if ({fin, dmaact, m_valid, m_last, busy, abort} !== 6'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 000000", {fin, dmaact, m_valid, m_last, busy, abort});
      end
      checks++;
      if ({dmaa, m_index, m_bfpexp, m_real, m_imag} !== '0) begin
         errors++; $display("FAIL reset_fields: got dmaa %0d idx %0d exp %0d re %0d im %0d want all 0", dmaa, m_index, m_bfpexp, m_real, m_imag);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_records();
      repeat (4) @(negedge clk);
      #4;
      checks++;
      if (busy !== 1'b0 || issued != 0 || m_valid !== 1'b0) begin
         errors++; $display("FAIL reset_idle: got busy %b reads %0d valid %b want 0 0 0", busy, issued, m_valid);
      end
   endtask

   task automatic test_full_frame();
      bit ok;
      start_frame(1'b0, -8'sd3, 0);
      wait_fin(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL full_fin: got no fin pulse want one within 200 cycles"); end
      checks++;
      if (acc_idx.size() != exp_n) begin errors++; $display("FAIL full_count: got %0d beats want %0d", acc_idx.size(), exp_n); end
      for (int i = 0; i < exp_n && i < acc_idx.size(); i++) begin
         checks++;
         if (acc_idx[i] !== AW'(i) || acc_re[i] !== mem_re[i] || acc_im[i] !== mem_im[i] || acc_last[i] !== (i == exp_n - 1)) begin
            errors++;
            $display("FAIL full_beat[%0d]: got idx %0d re %0d im %0d last %b want idx %0d re %0d im %0d last %b",
                     i, acc_idx[i], acc_re[i], acc_im[i], acc_last[i], i, mem_re[i], mem_im[i], i == exp_n - 1);
         end
      end
      checks++;
      if (addr_q.size() != N) begin
         errors++; $display("FAIL full_addr_count: got %0d reads want %0d", addr_q.size(), N);
      end else begin
         for (int i = 0; i < N; i++) begin
            checks++;
            if (addr_q[i] !== AW'(i) || addr_cyc[i] != addr_cyc[0] + i) begin
               errors++; $display("FAIL full_addr[%0d]: got addr %0d at +%0d want addr %0d at +%0d", i, addr_q[i], addr_cyc[i] - addr_cyc[0], i, i);
            end
         end
      end
      if (acc_cyc.size() == N && addr_cyc.size() > 0) begin
         checks++;
         if (acc_cyc[0] - addr_cyc[0] != 2) begin
            errors++; $display("FAIL full_latency: got first beat %0d cycles after first read want 2", acc_cyc[0] - addr_cyc[0]);
         end
         checks++;
         if (acc_cyc[N-1] - acc_cyc[0] != N - 1) begin
            errors++; $display("FAIL full_b2b: got %0d cycles for %0d beats want %0d", acc_cyc[N-1] - acc_cyc[0] + 1, N, N);
         end
      end
      checks++;
      if (bfp_bad != 0) begin errors++; $display("FAIL full_bfpexp: got %0d beats with wrong exponent want 0 (exp -3)", bfp_bad); end
      // done held high after fin: no second frame may start.
      repeat (10) @(negedge clk);
      #4;
      checks++;
      if (fin_cnt != 1 || issued != N || busy !== 1'b1) begin
         errors++; $display("FAIL full_hold: got fin %0d reads %0d busy %b want 1 %0d 1", fin_cnt, issued, busy, N);
      end
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      #4;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL full_release: got busy %b want 0 after done fell", busy); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      start_frame(1'b0, 8'sd5, 2);
      wait_fin(400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_fin: got no fin pulse want one within 400 cycles"); end
      checks++;
      if (acc_idx.size() != exp_n) begin errors++; $display("FAIL b2b_count: got %0d beats want %0d", acc_idx.size(), exp_n); end
      for (int i = 0; i < exp_n && i < acc_idx.size(); i++) begin
         checks++;
         if (acc_idx[i] !== AW'(i) || acc_re[i] !== mem_re[i] || acc_im[i] !== mem_im[i] || acc_last[i] !== (i == exp_n - 1)) begin
            errors++;
            $display("FAIL b2b_beat[%0d]: got idx %0d re %0d im %0d last %b want idx %0d re %0d im %0d last %b",
                     i, acc_idx[i], acc_re[i], acc_im[i], acc_last[i], i, mem_re[i], mem_im[i], i == exp_n - 1);
         end
      end
      checks++;
      if (stab_bad != 0 || max_out > 2 || bfp_bad != 0) begin
         errors++; $display("FAIL b2b_flow: got unstable %0d outstanding %0d badexp %0d want 0 <=2 0", stab_bad, max_out, bfp_bad);
      end
      end_frame();
   endtask

   task automatic test_half_spectrum();
      bit ok;
      logic signed [7:0] e;
      e = 8'($urandom);
      start_frame(1'b1, e, 0);
      wait_fin(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL half_fin: got no fin pulse want one within 200 cycles"); end
      checks++;
      if (acc_idx.size() != N / 2) begin errors++; $display("FAIL half_count: got %0d beats want %0d", acc_idx.size(), N / 2); end
      for (int i = 0; i < exp_n && i < acc_idx.size(); i++) begin
         checks++;
         if (acc_idx[i] !== AW'(i) || acc_re[i] !== mem_re[i] || acc_im[i] !== mem_im[i] || acc_last[i] !== (i == exp_n - 1)) begin
            errors++;
            $display("FAIL half_beat[%0d]: got idx %0d re %0d last %b want idx %0d re %0d last %b",
                     i, acc_idx[i], acc_re[i], acc_last[i], i, mem_re[i], i == exp_n - 1);
         end
      end
      checks++;
      if (addr_q.size() != N / 2) begin errors++; $display("FAIL half_reads: got %0d reads want %0d", addr_q.size(), N / 2); end
      foreach (addr_q[i]) begin
         checks++;
         if (addr_q[i] > AW'(N / 2 - 1)) begin errors++; $display("FAIL half_addr[%0d]: got %0d want at most %0d", i, addr_q[i], N / 2 - 1); end
      end
      checks++;
      if (bfp_bad != 0) begin errors++; $display("FAIL half_bfpexp: got %0d wrong exponent beats want 0", bfp_bad); end
      end_frame();
   endtask

   task automatic test_backpressure();
      bit ok;
      start_frame(1'b0, -8'sd7, 1);
      wait_fin(400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_fin: got no fin pulse want one within 400 cycles"); end
      checks++;
      if (acc_idx.size() != exp_n) begin errors++; $display("FAIL bp_count: got %0d beats want %0d", acc_idx.size(), exp_n); end
      for (int i = 0; i < exp_n && i < acc_idx.size(); i++) begin
         checks++;
         if (acc_idx[i] !== AW'(i) || acc_re[i] !== mem_re[i] || acc_im[i] !== mem_im[i] || acc_last[i] !== (i == exp_n - 1)) begin
            errors++;
            $display("FAIL bp_beat[%0d]: got idx %0d re %0d im %0d last %b want idx %0d re %0d im %0d last %b",
                     i, acc_idx[i], acc_re[i], acc_im[i], acc_last[i], i, mem_re[i], mem_im[i], i == exp_n - 1);
         end
      end
      checks++;
      if (stall_done !== 1'b1 || stab_bad != 0) begin
         errors++; $display("FAIL bp_stall: got stall_seen %b unstable %0d want 1 0", stall_done, stab_bad);
      end
      checks++;
      if (max_out > 2) begin errors++; $display("FAIL bp_outstanding: got %0d want at most 2", max_out); end
      end_frame();
   endtask

   task automatic test_abort();
      bit ok;
      start_frame(1'b0, 8'sd2, 0);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (accepted >= 6) ok = 1'b1;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL abort_reach6: got %0d beats want 6 within 100 cycles", accepted); end
      done = 1'b0;
      #4;
      checks++;
      if (abort !== 1'b1 || fin !== 1'b0 || dmaact !== 1'b0) begin
         errors++; $display("FAIL abort_pulse: got abort %b fin %b dmaact %b want 1 0 0", abort, fin, dmaact);
      end
      @(negedge clk);
      #4;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || abort !== 1'b0) begin
         errors++; $display("FAIL abort_after: got valid %b busy %b abort %b want 0 0 0", m_valid, busy, abort);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (fin_cnt != 0 || abort_cnt != 1 || accepted < 6 || accepted > 7) begin
         errors++; $display("FAIL abort_counts: got fin %0d abort %0d beats %0d want 0 1 6..7", fin_cnt, abort_cnt, accepted);
      end
      for (int i = 0; i < acc_idx.size(); i++) begin
         checks++;
         if (acc_idx[i] !== AW'(i) || acc_re[i] !== mem_re[i] || acc_im[i] !== mem_im[i]) begin
            errors++; $display("FAIL abort_beat[%0d]: got idx %0d re %0d want idx %0d re %0d", i, acc_idx[i], acc_re[i], i, mem_re[i]);
         end
      end
      // A fresh frame after the abort starts again from bin 0.
      start_frame(1'b0, -8'sd1, 0);
      wait_fin(200, ok);
      checks++;
      if (!ok || acc_idx.size() != N) begin
         errors++; $display("FAIL abort_restart: got fin %b beats %0d want 1 %0d", ok, acc_idx.size(), N);
      end
      for (int i = 0; i < exp_n && i < acc_idx.size(); i++) begin
         checks++;
         if (acc_idx[i] !== AW'(i) || acc_re[i] !== mem_re[i] || acc_im[i] !== mem_im[i] || acc_last[i] !== (i == exp_n - 1)) begin
            errors++; $display("FAIL abort_restart_beat[%0d]: got idx %0d re %0d want idx %0d re %0d", i, acc_idx[i], acc_re[i], i, mem_re[i]);
         end
      end
      end_frame();
   endtask

   task automatic test_async_reset();
      bit ok;
      start_frame(1'b0, 8'sd9, 0);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (issued >= 3) ok = 1'b1;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL areset_reach: got %0d reads want 3 within 50 cycles", issued); end
      #2;
      rst  = 1'b1;
      done = 1'b0;
      #1;
      checks++;
      if ({fin, dmaact, m_valid, m_last, busy, abort} !== 6'b0) begin
         errors++; $display("FAIL areset_flags: got %b want 000000", {fin, dmaact, m_valid, m_last, busy, abort});
      end
      checks++;
      if ({dmaa, m_index, m_bfpexp} !== '0) begin
         errors++; $display("FAIL areset_fields: got dmaa %0d idx %0d exp %0d want 0 0 0", dmaa, m_index, m_bfpexp);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_records();
      repeat (10) @(negedge clk);
      #4;
      checks++;
      if (issued != 0 || accepted != 0 || fin_cnt != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL areset_quiet: got reads %0d beats %0d fin %0d busy %b want 0 0 0 0", issued, accepted, fin_cnt, busy);
      end
   endtask

   initial begin
      clear_records();
      exp_bfp = '0;
      for (int i = 0; i < N; i++) begin
         mem_re[i] = '0;
         mem_im[i] = '0;
      end
      test_reset();
      test_full_frame();
      test_back_to_back();
      test_half_spectrum();
      test_backpressure();
      test_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
